// File: rtl/tpu_array_seq.sv
// Command sequencer for a DIM x DIM systolic MAC array: row load, one skewed
// operand wave with drain, and row readout, each finished by a one-cycle done.
module tpu_array_seq #(
   parameter int DIM    = 8,
   parameter int IDX_W  = 3,
   parameter int STEP_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd,
   output logic             cmd_ready,
   input  logic             stall,
   output logic             mac_en,
   output logic [DIM-1:0]   c_wren,
   output logic [IDX_W-1:0] c_row,
   output logic             rd_valid,
   output logic [IDX_W-1:0] ab_idx,
   output logic             ab_fetch,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOADC = 2'b01,
      MMUL  = 2'b10,
      READC = 2'b11
   } state_t;

   localparam logic [STEP_W-1:0] LAST_ROW  = STEP_W'(DIM - 1);
   localparam logic [STEP_W-1:0] LAST_MMUL = STEP_W'(3 * DIM - 3);
   localparam logic [STEP_W-1:0] FEED_LEN  = STEP_W'(DIM);

   if (DIM < 2 || IDX_W != $clog2(DIM) || (3 * DIM - 2) >= (1 << STEP_W)) begin : g_param_check
      $error("tpu_array_seq: inconsistent DIM/IDX_W/STEP_W");
   end

   function automatic logic [DIM-1:0] row_onehot(input logic [STEP_W-1:0] s);
      row_onehot = {{(DIM-1){1'b0}}, 1'b1} << s;
   endfunction

   state_t            state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              done_q, done_d;
   logic              mac_en_q, mac_en_d;
   logic [DIM-1:0]    c_wren_q, c_wren_d;
   logic [IDX_W-1:0]  c_row_q, c_row_d;
   logic              rd_valid_q, rd_valid_d;
   logic [IDX_W-1:0]  ab_idx_q, ab_idx_d;
   logic              ab_fetch_q, ab_fetch_d;

   // Next state and step: a stalled cycle holds both; the terminal step is exact.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd != 2'b00) begin
               state_d = state_t'(cmd);
               step_d  = '0;
            end
         end
         LOADC, READC: begin
            if (!stall) begin
               if (step_q == LAST_ROW) begin
                  state_d = IDLE;
                  step_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         MMUL: begin
            if (!stall) begin
               if (step_q == LAST_MMUL) begin
                  state_d = IDLE;
                  step_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            step_d  = '0;
         end
      endcase
   end

   // Output registers describe the step that will be current next cycle.
   always_comb begin
      mac_en_d   = 1'b0;
      c_wren_d   = '0;
      c_row_d    = '0;
      rd_valid_d = 1'b0;
      ab_idx_d   = '0;
      ab_fetch_d = 1'b0;
      case (state_d)
         LOADC: begin
            c_wren_d = row_onehot(step_d);
            c_row_d  = step_d[IDX_W-1:0];
         end
         MMUL: begin
            mac_en_d = 1'b1;
            if (step_d < FEED_LEN) begin
               ab_fetch_d = 1'b1;
               ab_idx_d   = step_d[IDX_W-1:0];
            end
         end
         READC: begin
            rd_valid_d = 1'b1;
            c_row_d    = step_d[IDX_W-1:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         step_q     <= '0;
         done_q     <= 1'b0;
         mac_en_q   <= 1'b0;
         c_wren_q   <= '0;
         c_row_q    <= '0;
         rd_valid_q <= 1'b0;
         ab_idx_q   <= '0;
         ab_fetch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         done_q     <= done_d;
         mac_en_q   <= mac_en_d;
         c_wren_q   <= c_wren_d;
         c_row_q    <= c_row_d;
         rd_valid_q <= rd_valid_d;
         ab_idx_q   <= ab_idx_d;
         ab_fetch_q <= ab_fetch_d;
      end
   end

   // A stalled cycle suppresses the strobes but keeps the indices on the bus.
   assign mac_en    = mac_en_q & ~stall;
   assign c_wren    = stall ? '0 : c_wren_q;
   assign rd_valid  = rd_valid_q & ~stall;
   assign ab_fetch  = ab_fetch_q & ~stall;
   assign c_row     = c_row_q;
   assign ab_idx    = ab_idx_q;
   assign done      = done_q;
   assign busy      = (state_q != IDLE);
   assign cmd_ready = (state_q == IDLE);

endmodule

// File: tb/tb_tpu_array_seq.sv
// Bench for tpu_array_seq at DIM=4: directed table, async reset mid-command,
// and randomized commands/stalls against a step-queue reference model.
module tb_tpu_array_seq;

   localparam int DIM    = 4;
   localparam int IDX_W  = 2;
   localparam int STEP_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic [1:0]       cmd;
   logic             cmd_ready;
   logic             stall;
   logic             mac_en;
   logic [DIM-1:0]   c_wren;
   logic [IDX_W-1:0] c_row;
   logic             rd_valid;
   logic [IDX_W-1:0] ab_idx;
   logic             ab_fetch;
   logic             busy;
   logic             done;

   tpu_array_seq #(.DIM(DIM), .IDX_W(IDX_W), .STEP_W(STEP_W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
      .stall(stall), .mac_en(mac_en), .c_wren(c_wren), .c_row(c_row),
      .rd_valid(rd_valid), .ab_idx(ab_idx), .ab_fetch(ab_fetch), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DIM-1:0]   wren;
      logic [IDX_W-1:0] row;
      logic             mac;
      logic             rdv;
      logic             fetch;
      logic [IDX_W-1:0] idx;
      logic             busy;
      logic             done;
      logic             ready;
   } outs_t;

   typedef struct {
      logic       v;
      logic [1:0] c;
      logic       s;
      outs_t      e;
   } vec_t;

   int vectors = 0;
   int miscompares = 0;
   vec_t tbl[$];

   // reference model: remaining steps of the running command
   int mq[$];
   int mcmd = 0;
   bit mdone = 1'b0;

   function automatic outs_t mk(input logic [DIM-1:0] w, input int r, input logic m,
                                input logic rv, input logic f, input int ix,
                                input logic b, input logic d);
      outs_t o;
      o.wren = w; o.row = IDX_W'(r); o.mac = m; o.rdv = rv; o.fetch = f;
      o.idx = IDX_W'(ix); o.busy = b; o.done = d; o.ready = ~b;
      return o;
   endfunction

   function automatic outs_t sample();
      outs_t o;
      o.wren = c_wren; o.row = c_row; o.mac = mac_en; o.rdv = rd_valid; o.fetch = ab_fetch;
      o.idx = ab_idx; o.busy = busy; o.done = done; o.ready = cmd_ready;
      return o;
   endfunction

   task automatic check(input string name, input outs_t act, input outs_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got wren=%b row=%0d mac=%b rdv=%b fetch=%b idx=%0d busy=%b done=%b ready=%b, required wren=%b row=%0d mac=%b rdv=%b fetch=%b idx=%0d busy=%b done=%b ready=%b",
                  name, act.wren, act.row, act.mac, act.rdv, act.fetch, act.idx, act.busy, act.done, act.ready,
                  exp.wren, exp.row, exp.mac, exp.rdv, exp.fetch, exp.idx, exp.busy, exp.done, exp.ready);
      end
   endtask

   task automatic drive_cycle(input logic v, input logic [1:0] c, input logic s, output outs_t act);
      @(posedge clk);
      #1;
      cmd_valid = v; cmd = c; stall = s;
      @(negedge clk);
      act = sample();
   endtask

   task automatic add(input logic v, input logic [1:0] c, input logic s, input outs_t e);
      vec_t r;
      r.v = v; r.c = c; r.s = s; r.e = e;
      tbl.push_back(r);
   endtask

   function automatic outs_t model_expect(input logic s);
      outs_t o;
      int st;
      o = '0;
      if (mq.size() > 0) begin
         o.busy = 1'b1;
         st = mq[0];
         case (mcmd)
            1: begin o.row = IDX_W'(st); if (!s) o.wren = DIM'(1) << st; end
            2: begin
               if (st < DIM) o.idx = IDX_W'(st);
               if (!s) begin o.mac = 1'b1; o.fetch = (st < DIM); end
            end
            default: begin o.row = IDX_W'(st); if (!s) o.rdv = 1'b1; end
         endcase
      end else begin
         o.ready = 1'b1;
         o.done = mdone;
      end
      return o;
   endfunction

   task automatic model_update(input logic v, input logic [1:0] c, input logic s);
      int len;
      if (mq.size() > 0) begin
         mdone = 1'b0;
         if (!s) begin
            void'(mq.pop_front());
            if (mq.size() == 0) mdone = 1'b1;
         end
      end else begin
         mdone = 1'b0;
         if (v && c != 2'b00) begin
            mcmd = int'(c);
            len = (c == 2'b10) ? 3 * DIM - 2 : DIM;
            for (int i = 0; i < len; i++) mq.push_back(i);
         end
      end
   endtask

   initial begin
      outs_t act, zero_idle;
      zero_idle = mk('0, 0, 0, 0, 0, 0, 0, 0);
      cmd_valid = 1'b0; cmd = 2'b00; stall = 1'b0; rst = 1'b1;
      #2;
      check("reset_state", sample(), zero_idle);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b0, 2'b00, 1'b0, act);
         check($sformatf("idle[%0d]", i), act, zero_idle);
      end

      // directed table: LOAD_C, stalled MATMUL, READ_C back-to-back, NOP
      add(1, 2'b01, 0, zero_idle);
      for (int i = 0; i < DIM; i++) add(0, 2'b00, 0, mk(DIM'(1) << i, i, 0, 0, 0, 0, 1, 0));
      add(1, 2'b10, 0, mk('0, 0, 0, 0, 0, 0, 0, 1));
      add(0, 2'b00, 0, mk('0, 0, 1, 0, 1, 0, 1, 0));
      add(0, 2'b00, 0, mk('0, 0, 1, 0, 1, 1, 1, 0));
      add(0, 2'b00, 1, mk('0, 0, 0, 0, 0, 2, 1, 0));
      add(0, 2'b00, 1, mk('0, 0, 0, 0, 0, 2, 1, 0));
      add(0, 2'b00, 0, mk('0, 0, 1, 0, 1, 2, 1, 0));
      add(1, 2'b01, 0, mk('0, 0, 1, 0, 1, 3, 1, 0));
      for (int i = 0; i < 2 * DIM - 2; i++) add(0, 2'b00, 0, mk('0, 0, 1, 0, 0, 0, 1, 0));
      add(1, 2'b11, 0, mk('0, 0, 0, 0, 0, 0, 0, 1));
      for (int i = 0; i < DIM; i++) add(0, 2'b00, 0, mk('0, i, 0, 1, 0, 0, 1, 0));
      add(1, 2'b00, 1, mk('0, 0, 0, 0, 0, 0, 0, 1));
      add(1, 2'b00, 0, zero_idle);
      add(0, 2'b00, 0, zero_idle);
      for (int i = 0; i < tbl.size(); i++) begin
         drive_cycle(tbl[i].v, tbl[i].c, tbl[i].s, act);
         check($sformatf("table[%0d]", i), act, tbl[i].e);
      end

      // async reset while MATMUL is at step 4
      drive_cycle(1'b1, 2'b10, 1'b0, act);
      for (int i = 0; i < 5; i++) drive_cycle(1'b0, 2'b00, 1'b0, act);
      check("mmul_step4", act, mk('0, 0, 1, 0, 0, 0, 1, 0));
      #1;
      rst = 1'b1;
      #1;
      check("async_reset_mid_mmul", sample(), zero_idle);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         drive_cycle(1'b0, 2'b00, 1'b0, act);
         check($sformatf("post_reset[%0d]", i), act, zero_idle);
      end

      // randomized commands and stalls against the reference model
      mq.delete();
      mdone = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         logic v, s;
         logic [1:0] c;
         v = ($urandom_range(0, 2) == 0);
         c = 2'($urandom_range(0, 3));
         s = ($urandom_range(0, 3) == 0);
         drive_cycle(v, c, s, act);
         check($sformatf("rand[%0d]", i), act, model_expect(s));
         model_update(v, c, s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tpu_array_seq.md
Name: tpu_array_seq

Overview:
Sequencer for the DIM x DIM systolic array of MAC cells: on one command it loads the accumulator rows, streams one skewed A/B operand wave, or reads accumulator rows out. It produces the array-wide MAC enable, the per-row accumulator write enables and the operand/row indices for the feeder and result buffers. It accepts one command at a time through a valid/ready handshake and signals completion with a one-cycle pulse.

Parameters:
DIM, 8, array dimension (rows = columns = DIM); must be >= 2
IDX_W, 3, index width; must equal clog2(DIM)
STEP_W, 5, step counter width; must hold 3*DIM-2

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd  input  2  00 NOP, 01 LOAD_C, 10 MATMUL, 11 READ_C
cmd_ready  output  1  high only in IDLE
stall  input  1  downstream/upstream not ready; freezes sequencing
mac_en  output  1  array-wide MAC/shift enable
c_wren  output  DIM  one-hot accumulator row write enable
c_row  output  IDX_W  row index for LOAD_C source or READ_C destination
rd_valid  output  1  READ_C: accumulator row c_row is valid this cycle
ab_idx  output  IDX_W  MATMUL: operand index k fetched by the A/B feeder
ab_fetch  output  1  MATMUL: feeder presents operand k; when low, feeder drives zeros
busy  output  1  state != IDLE
done  output  1  one-cycle pulse on command completion

Behaviour:
- States: IDLE, LOADC, MMUL, READC. Single step counter `step` (STEP_W bits).
- Reset (async, any time, mid-command included): state IDLE, step=0, every registered output 0 (mac_en, c_wren, c_row, rd_valid, ab_idx, ab_fetch, done). Any command in flight is abandoned.
- cmd_ready = (state==IDLE), combinational. Accept = cmd_valid & cmd_ready.
- NOP accepted: no state change, no done.
- Accept at edge T: state moves to the command state, step=0. First active outputs appear in the cycle after T, because all outputs are registered.
- Stall: while stall=1 in a non-IDLE state, step, state and indices hold. mac_en, c_wren, rd_valid and ab_fetch are 0 that cycle. Active outputs resume on the first cycle with stall=0, with the same step value. stall has no effect in IDLE.
- LOADC:
  - DIM active cycles, step 0..DIM-1.
  - Each active cycle: c_wren = one-hot(step), c_row = step, mac_en = 0.
- MMUL:
  - 3*DIM-2 active cycles, step 0..3*DIM-3.
  - Each active cycle: mac_en = 1.
  - For step < DIM: ab_fetch = 1 and ab_idx = step.
  - Otherwise: ab_fetch = 0 and ab_idx = 0; the feeder injects zeros while the wavefront drains.
  - c_wren stays 0 throughout, so the accumulators keep accumulating.
- READC:
  - DIM active cycles, step 0..DIM-1.
  - Each active cycle: rd_valid = 1, c_row = step, mac_en = 0.
- Completion:
  - The final active step's registers are presented in cycle L.
  - In cycle L+1: done = 1, busy = 0, all active outputs 0, state IDLE. A new command can be accepted at the end of this cycle.
  - Back-to-back commands have no dead cycle beyond the done cycle.
- A stall asserted in the done cycle is ignored.
- cmd values arriving while busy are not sampled.
- Counter does not wrap: the terminal comparison is exact (DIM-1 or 3*DIM-3), and step is reset to 0 on every accept.

Test Plan:
- Reset, then idle 5 cycles -> cmd_ready=1, busy=0, all outputs 0. Assert rst mid-MMUL at step 4 -> outputs 0 asynchronously; after release, state IDLE and no done pulse.
- DIM=4, LOAD_C accepted at T -> cycles T+1..T+4: c_wren=0001,0010,0100,1000 and c_row 0..3; done at T+5; busy high T+1..T+4.
- DIM=4, MATMUL at T -> mac_en high T+1..T+10; ab_fetch high with ab_idx 0..3 at T+1..T+4; ab_fetch low T+5..T+10; done at T+11; c_wren always 0.
- DIM=4, MATMUL with stall high for 2 cycles at step 2 -> ab_idx stays 2, mac_en=0 for those 2 cycles, done delayed to T+13; total mac_en-high cycles still 10.
- DIM=4, READ_C immediately accepted in the MATMUL done cycle -> rd_valid with c_row 0..3 on the following 4 cycles, then done; NOP with cmd_valid in IDLE -> no busy, no done.
